stg_ia: RTL and testbench

Instruction-address stage ahead of the fetch latch. It owns the fetch PC, issues read requests to the synchronous (1-cycle latency) instruction memory port, and drives the PC and valid that the fetch latch samples together with the returned memory word. It also handles pipeline stall, redirects from branch resolution, and loss of the shared memory port.

---
 rtl/stg_ia_pkg.sv | 15 +
 rtl/stg_ia_perf_cnt.sv | 15 +
 rtl/stg_ia.sv | 123 ++++++++++++
 tb/tb_stg_ia.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stg_ia_pkg.sv
// Shared definitions for the instruction-address stage: address width,
// state encoding and the default PC increment.
package stg_ia_pkg;
  localparam int SIZE_ADDR  = 32;
  localparam int PC_INC_DEF = 1;

  typedef enum logic [1:0] {
    IA_BOOT = 2'd0,
    IA_RUN  = 2'd1,
    IA_HOLD = 2'd2,
    IA_LOST = 2'd3
  } ia_state_e;

  typedef logic [SIZE_ADDR-1:0] ia_addr_t;
endpackage

// File: rtl/stg_ia_perf_cnt.sv
// Saturating event counter used by the optional fetch/bubble statistics.
module ia_perf_cnt #(
  parameter int W = 32
) (
  input  logic         iw_clk,
  input  logic         iw_rst_n,
  input  logic         iw_inc,
  output logic [W-1:0] ow_cnt
);
  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n)                  ow_cnt <= '0;
    else if (iw_inc && ow_cnt != '1) ow_cnt <= ow_cnt + 1'b1;
  end
endmodule

// File: rtl/stg_ia.sv
// Instruction-address stage: owns the fetch PC, requests words from the
// 1-cycle instruction memory and tags the returned word with PC/valid.
// Optional build macro AMBER_IA_PERF_EN adds fetch/bubble counters.
module stg_ia
  import stg_ia_pkg::*;
#(
  parameter ia_addr_t RESET_VECTOR = '0,
  parameter ia_addr_t PC_INC       = ia_addr_t'(PC_INC_DEF)
) (
  input  logic     iw_clk,
  input  logic     iw_rst_n,
  input  logic     iw_stall,
  input  logic     iw_redirect,
  input  ia_addr_t iw_redirect_pc,
  input  logic     iw_mem_gnt,
  output logic     ow_mem_req,
  output ia_addr_t ow_mem_addr,
  output ia_addr_t ow_pc,
  output logic     ow_ia_valid
`ifdef AMBER_IA_PERF_EN
  ,
  output logic [31:0] ow_perf_fetch,
  output logic [31:0] ow_perf_bubble
`endif
);
  ia_state_e state, nx_state;
  ia_addr_t  r_pc, r_last, nx_pc, nx_last, nx_opc;
  logic      nx_vld;
  // run_rules: cycle follows the normal issue rules (RUN, or HOLD on release)
  // replay:    stall dropped while the bus word was lost; rewind to r_last
  logic      run_rules, replay;

  // State and PC registers; reset discards any in-flight word via valid=0.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state       <= IA_BOOT;
      r_pc        <= RESET_VECTOR;
      r_last      <= RESET_VECTOR;
      ow_pc       <= '0;
      ow_ia_valid <= 1'b0;
    end else begin
      state       <= nx_state;
      r_pc        <= nx_pc;
      r_last      <= nx_last;
      ow_pc       <= nx_opc;
      ow_ia_valid <= nx_vld;
    end
  end

  // Next-state and request decode; redirect overrides stall and grant.
  always_comb begin
    nx_state    = state;
    nx_pc       = r_pc;
    nx_last     = r_last;
    nx_opc      = ow_pc;
    nx_vld      = ow_ia_valid;
    ow_mem_req  = 1'b0;
    ow_mem_addr = r_pc;
    run_rules   = 1'b0;
    replay      = 1'b0;
    if (iw_redirect) begin
      nx_state = IA_RUN;
      nx_pc    = iw_redirect_pc;
      nx_vld   = 1'b0;
    end else begin
      case (state)
        IA_BOOT: nx_state = IA_RUN;
        IA_RUN: begin
          if (iw_stall) nx_state = IA_HOLD;
          else          run_rules = 1'b1;
        end
        IA_HOLD: begin
          if (iw_stall) begin
            // keep the stalled word on the bus by re-reading it
            ow_mem_addr = r_last;
            ow_mem_req  = 1'b1;
            if (!iw_mem_gnt) nx_state = IA_LOST;
          end else run_rules = 1'b1;
        end
        IA_LOST: begin
          if (iw_stall) begin
            ow_mem_addr = r_last;
            ow_mem_req  = 1'b1;
            if (iw_mem_gnt) nx_state = IA_HOLD;
          end else replay = 1'b1;
        end
        default: nx_state = IA_BOOT;
      endcase
      if (replay) begin
        ow_mem_addr = r_last;
        nx_pc       = r_last;
        nx_vld      = 1'b0;
        nx_state    = IA_RUN;
      end
      if (run_rules) begin
        nx_state   = IA_RUN;
        ow_mem_req = 1'b1;
        if (iw_mem_gnt) begin
          nx_last = r_pc;
          nx_pc   = r_pc + PC_INC;
          nx_opc  = r_pc;
          nx_vld  = 1'b1;
        end else nx_vld = 1'b0;
      end
    end
  end

`ifdef AMBER_IA_PERF_EN
  logic perf_issue, perf_bubble;
  // Issue = granted request under run rules; bubble = denied grant or replay.
  always_comb begin
    perf_issue  = run_rules & iw_mem_gnt;
    perf_bubble = (run_rules & ~iw_mem_gnt) | replay;
  end

  ia_perf_cnt #(.W(32)) u_fetch_cnt (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_inc(perf_issue), .ow_cnt(ow_perf_fetch)
  );
  ia_perf_cnt #(.W(32)) u_bubble_cnt (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_inc(perf_bubble), .ow_cnt(ow_perf_bubble)
  );
`endif
endmodule

// File: tb/tb_stg_ia.sv
// Self-checking bench for stg_ia: directed scenarios plus randomized traffic
// checked against a flag-based behavioural model of the fetch stage.
module tb_stg_ia;
  localparam logic [31:0] RV = 32'h100;

  logic        iw_clk, iw_rst_n, iw_stall, iw_redirect, iw_mem_gnt;
  logic [31:0] iw_redirect_pc, ow_mem_addr, ow_pc;
  logic        ow_mem_req, ow_ia_valid;
`ifdef AMBER_IA_PERF_EN
  logic [31:0] ow_perf_fetch, ow_perf_bubble;
`endif

  int vec, err;

  // model: boot pending, stalled, bus word lost, and the address bookkeeping
  bit          m_boot, m_stl, m_lost, m_vld, e_req;
  logic [31:0] m_pc, m_last, m_opc, e_addr;
  int unsigned m_fetch, m_bub;

  stg_ia #(.RESET_VECTOR(RV)) dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_stall(iw_stall),
    .iw_redirect(iw_redirect), .iw_redirect_pc(iw_redirect_pc),
    .iw_mem_gnt(iw_mem_gnt), .ow_mem_req(ow_mem_req), .ow_mem_addr(ow_mem_addr),
    .ow_pc(ow_pc), .ow_ia_valid(ow_ia_valid)
`ifdef AMBER_IA_PERF_EN
    , .ow_perf_fetch(ow_perf_fetch), .ow_perf_bubble(ow_perf_bubble)
`endif
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  task automatic m_reset();
    m_boot = 1; m_stl = 0; m_lost = 0; m_vld = 0;
    m_pc = RV; m_last = RV; m_opc = 0; m_fetch = 0; m_bub = 0;
  endtask

  // apply inputs for this cycle and derive the expected request/address
  task automatic drive(input bit s, input bit r, input bit g, input logic [31:0] rp);
    iw_stall = s; iw_redirect = r; iw_mem_gnt = g; iw_redirect_pc = rp;
    e_addr = m_pc;
    if (m_boot || r)  e_req = 0;
    else if (!m_stl)  e_req = !s;
    else if (s)       begin e_req = 1; e_addr = m_last; end
    else              e_req = !m_lost;
    #1;
  endtask

  // clock edge: advance the model from the inputs held across the edge
  task automatic tick();
    @(posedge iw_clk);
    if (iw_redirect) begin
      m_pc = iw_redirect_pc; m_vld = 0; m_boot = 0; m_stl = 0; m_lost = 0;
    end else if (m_boot) m_boot = 0;
    else if (m_stl && iw_stall) m_lost = !iw_mem_gnt;
    else if (m_stl && m_lost) begin
      m_vld = 0; m_pc = m_last; m_stl = 0; m_lost = 0; m_bub++;
    end else if (iw_stall) begin
      m_stl = 1; m_lost = 0;
    end else begin
      m_stl = 0;
      if (iw_mem_gnt) begin
        m_last = m_pc; m_opc = m_pc; m_pc = m_pc + 32'd1; m_vld = 1; m_fetch++;
      end else begin
        m_vld = 0; m_bub++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    iw_rst_n = 0; iw_stall = 0; iw_redirect = 0; iw_mem_gnt = 1; iw_redirect_pc = 0;
    m_reset();
    #12;
    vec++; if (ow_ia_valid !== 1'b0) begin err++; $display("FAIL reset_valid got=%b exp=0", ow_ia_valid); end
    vec++; if (ow_pc !== 32'h0) begin err++; $display("FAIL reset_pc got=%h exp=0", ow_pc); end
    vec++; if (ow_mem_req !== 1'b0) begin err++; $display("FAIL reset_req got=%b exp=0", ow_mem_req); end
    @(posedge iw_clk); #1; iw_rst_n = 1; #1;
  endtask

  task automatic test_stream();
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_req !== 1'b0) begin err++; $display("FAIL boot_req got=%b exp=0", ow_mem_req); end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      vec++; if (ow_mem_req !== e_req || ow_mem_addr !== RV + 32'(i))
        begin err++; $display("FAIL stream_addr%0d got=%b/%h exp=%b/%h", i, ow_mem_req, ow_mem_addr, e_req, RV + 32'(i)); end
      tick();
      vec++; if (ow_ia_valid !== 1'b1 || ow_pc !== RV + 32'(i))
        begin err++; $display("FAIL stream_pc%0d got=%b/%h exp=1/%h", i, ow_ia_valid, ow_pc, RV + 32'(i)); end
    end
  endtask

  // stall three cycles with grant: word 0x104 stays tagged, 0x105 issues on release
  task automatic test_stall_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0);
      vec++; if (ow_mem_req !== 1'b1 && i > 0) begin err++; $display("FAIL hold_req%0d got=%b exp=1", i, ow_mem_req); end
      vec++; if (i > 0 && ow_mem_addr !== 32'h104) begin err++; $display("FAIL hold_addr%0d got=%h exp=104", i, ow_mem_addr); end
      vec++; if (ow_mem_req !== e_req) begin err++; $display("FAIL hold_model_req%0d got=%b exp=%b", i, ow_mem_req, e_req); end
      tick();
      vec++; if (ow_ia_valid !== 1'b1 || ow_pc !== 32'h104)
        begin err++; $display("FAIL hold_pc%0d got=%b/%h exp=1/104", i, ow_ia_valid, ow_pc); end
    end
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_req !== 1'b1 || ow_mem_addr !== 32'h105)
      begin err++; $display("FAIL release_addr got=%b/%h exp=1/105", ow_mem_req, ow_mem_addr); end
    tick();
    vec++; if (ow_ia_valid !== 1'b1 || ow_pc !== 32'h105)
      begin err++; $display("FAIL release_pc got=%b/%h exp=1/105", ow_ia_valid, ow_pc); end
  endtask

  // re-read misses while stalled, stall drops in LOST: bubble then replay
  task automatic test_lost();
    logic [31:0] la;
    la = m_last;
    drive(1, 0, 1, 0); tick();
    drive(1, 0, 0, 0);
    vec++; if (ow_mem_req !== 1'b1 || ow_mem_addr !== la)
      begin err++; $display("FAIL lost_reread got=%b/%h exp=1/%h", ow_mem_req, ow_mem_addr, la); end
    tick();
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_req !== 1'b0) begin err++; $display("FAIL lost_drop_req got=%b exp=0", ow_mem_req); end
    tick();
    vec++; if (ow_ia_valid !== 1'b0) begin err++; $display("FAIL lost_bubble got=%b exp=0", ow_ia_valid); end
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_req !== 1'b1 || ow_mem_addr !== la)
      begin err++; $display("FAIL replay_addr got=%b/%h exp=1/%h", ow_mem_req, ow_mem_addr, la); end
    tick();
    vec++; if (ow_ia_valid !== 1'b1 || ow_pc !== la)
      begin err++; $display("FAIL replay_pc got=%b/%h exp=1/%h", ow_ia_valid, ow_pc, la); end
  endtask

  task automatic test_redirect();
    drive(1, 0, 1, 0); tick();
    drive(1, 1, 1, 32'h200);
    vec++; if (ow_mem_req !== 1'b0) begin err++; $display("FAIL redir_req got=%b exp=0", ow_mem_req); end
    tick();
    vec++; if (ow_ia_valid !== 1'b0) begin err++; $display("FAIL redir_kill got=%b exp=0", ow_ia_valid); end
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_req !== 1'b1 || ow_mem_addr !== 32'h200)
      begin err++; $display("FAIL redir_addr got=%b/%h exp=1/200", ow_mem_req, ow_mem_addr); end
    tick();
    vec++; if (ow_ia_valid !== 1'b1 || ow_pc !== 32'h200)
      begin err++; $display("FAIL redir_pc got=%b/%h exp=1/200", ow_ia_valid, ow_pc); end
  endtask

  // issue from all-ones wraps to zero; a denied grant holds the PC
  task automatic test_wrap();
    drive(0, 1, 1, 32'hFFFF_FFFF); tick();
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_addr !== 32'hFFFF_FFFF) begin err++; $display("FAIL wrap_top got=%h exp=ffffffff", ow_mem_addr); end
    tick();
    drive(0, 0, 0, 0);
    vec++; if (ow_mem_req !== 1'b1 || ow_mem_addr !== 32'h0)
      begin err++; $display("FAIL wrap_zero got=%b/%h exp=1/0", ow_mem_req, ow_mem_addr); end
    tick();
    vec++; if (ow_ia_valid !== 1'b0) begin err++; $display("FAIL nogrant_bubble got=%b exp=0", ow_ia_valid); end
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_addr !== 32'h0) begin err++; $display("FAIL nogrant_hold got=%h exp=0", ow_mem_addr); end
    tick();
  endtask

  task automatic test_random();
    bit s, r, g;
    logic [31:0] rp;
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 11) == 0);
      g  = ($urandom_range(0, 3) != 0);
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      drive(s, r, g, rp);
      vec++; if (ow_mem_req !== e_req)
        begin err++; $display("FAIL rnd_req c%0d got=%b exp=%b", i, ow_mem_req, e_req); end
      if (e_req) begin
        vec++; if (ow_mem_addr !== e_addr)
          begin err++; $display("FAIL rnd_addr c%0d got=%h exp=%h", i, ow_mem_addr, e_addr); end
      end
      tick();
      vec++; if (ow_ia_valid !== m_vld)
        begin err++; $display("FAIL rnd_valid c%0d got=%b exp=%b", i, ow_ia_valid, m_vld); end
      if (m_vld) begin
        vec++; if (ow_pc !== m_opc)
          begin err++; $display("FAIL rnd_pc c%0d got=%h exp=%h", i, ow_pc, m_opc); end
      end
`ifdef AMBER_IA_PERF_EN
      vec++; if (ow_perf_fetch !== m_fetch || ow_perf_bubble !== m_bub)
        begin err++; $display("FAIL rnd_perf c%0d got=%0d/%0d exp=%0d/%0d", i, ow_perf_fetch, ow_perf_bubble, m_fetch, m_bub); end
`endif
    end
  endtask

  // asynchronous reset in the middle of a cycle clears outputs at once
  task automatic test_reset_mid();
    drive(0, 0, 1, 0);
    #2 iw_rst_n = 0; m_reset(); #1;
    vec++; if (ow_ia_valid !== 1'b0 || ow_pc !== 32'h0)
      begin err++; $display("FAIL midrst_out got=%b/%h exp=0/0", ow_ia_valid, ow_pc); end
    vec++; if (ow_mem_req !== 1'b0) begin err++; $display("FAIL midrst_req got=%b exp=0", ow_mem_req); end
`ifdef AMBER_IA_PERF_EN
    vec++; if (ow_perf_fetch !== 32'd0 || ow_perf_bubble !== 32'd0)
      begin err++; $display("FAIL midrst_perf got=%0d/%0d exp=0/0", ow_perf_fetch, ow_perf_bubble); end
`endif
    @(posedge iw_clk); #1; iw_rst_n = 1; #1;
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 1, 0);
    vec++; if (ow_mem_req !== 1'b1 || ow_mem_addr !== RV)
      begin err++; $display("FAIL midrst_restart got=%b/%h exp=1/%h", ow_mem_req, ow_mem_addr, RV); end
    tick();
  endtask

`ifdef AMBER_IA_PERF_EN
  // ten issues and three denied grants after a fresh reset
  task automatic test_perf();
    test_reset();
    drive(0, 0, 1, 0); tick();
    for (int i = 0; i < 13; i++) begin
      drive(0, 0, !(i == 2 || i == 6 || i == 10), 0); tick();
    end
    vec++; if (ow_perf_fetch !== 32'd10 || ow_perf_bubble !== 32'd3)
      begin err++; $display("FAIL perf_count got=%0d/%0d exp=10/3", ow_perf_fetch, ow_perf_bubble); end
    vec++; if (ow_perf_fetch !== m_fetch || ow_perf_bubble !== m_bub)
      begin err++; $display("FAIL perf_model got=%0d/%0d exp=%0d/%0d", ow_perf_fetch, ow_perf_bubble, m_fetch, m_bub); end
  endtask
`endif

  initial begin
    vec = 0; err = 0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_lost();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef AMBER_IA_PERF_EN
    test_perf();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
